// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// field length in bytes and a mod-2**32 word-sum helper for the checksum.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } loader_state_t;

    localparam int          LOADER_LEN_BYTES = 4;
    localparam logic [1:0]  LAST_LANE        = 2'(LOADER_LEN_BYTES - 1);

    function automatic logic [31:0] word_sum(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: UART byte stream in, instruction-memory write port and
// load status out. The slave modport is the loader's view.
interface imem_loader_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;

    modport master (
        output rx_data, rx_valid,
        input  imem_we, imem_waddr, imem_wdata, cpu_reset, load_done, load_err
    );

    modport slave (
        input  rx_data, rx_valid,
        output imem_we, imem_waddr, imem_wdata, cpu_reset, load_done, load_err
    );
endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// byte_word_packer: gathers four strobed bytes into a little-endian word.
// word/word_valid are presented combinationally alongside the 4th byte so the
// consumer can register the result on the same edge that takes that byte.
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic [7:0]  rx_byte,
    input  logic        byte_valid,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [1:0]  lane_r;
    logic [23:0] bytes_r;

    // Lane counter and storage for the first three bytes of a word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_r  <= 2'd0;
            bytes_r <= 24'd0;
        end else if (restart) begin
            lane_r  <= 2'd0;
            bytes_r <= bytes_r;
        end else if (byte_valid) begin
            case (lane_r)
                2'd0:    bytes_r[7:0]   <= rx_byte;
                2'd1:    bytes_r[15:8]  <= rx_byte;
                2'd2:    bytes_r[23:16] <= rx_byte;
                default: bytes_r        <= bytes_r;
            endcase
            lane_r <= lane_r + 2'd1;
        end else begin
            lane_r  <= lane_r;
            bytes_r <= bytes_r;
        end
    end

    // Completed word appears together with its final byte.
    always_comb begin
        word       = {rx_byte, bytes_r};
        word_valid = 1'b0;
        if (byte_valid && !restart && (lane_r == LAST_LANE)) begin
            word_valid = 1'b1;
        end else begin
            word_valid = 1'b0;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes a length-prefixed LE word stream into instruction memory
// from address 0 and holds the core in reset until the image is loaded.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing sum-of-words check).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    loader_state_t state_r;
    logic [31:0]   n_r;
    logic [31:0]   count_r;
    logic [31:0]   word_s;
    logic          word_valid_s;
    logic          active_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   csum_r;
`endif

    // Bytes are only consumed while a field is still expected.
    always_comb begin
        active_s = 1'b0;
        case (state_r)
            S_LEN, S_DATA, S_CSUM: active_s = 1'b1;
            default:               active_s = 1'b0;
        endcase
    end

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .restart    (!active_s),
        .rx_byte    (bus.rx_data),
        .byte_valid (bus.rx_valid && active_s),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Loader FSM with registered memory-write port and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= S_LEN;
            n_r            <= 32'd0;
            count_r        <= 32'd0;
            bus.imem_we    <= 1'b0;
            bus.imem_waddr <= '0;
            bus.imem_wdata <= 32'd0;
            bus.cpu_reset  <= 1'b1;
            bus.load_done  <= 1'b0;
            bus.load_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r         <= 32'd0;
`endif
        end else begin
            bus.imem_we <= 1'b0;
            if (word_valid_s) begin
                case (state_r)
                    S_LEN: begin
                        n_r     <= word_s;
                        count_r <= 32'd0;
                        if (word_s == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_r <= S_CSUM;
`else
                            state_r       <= S_DONE;
                            bus.load_done <= 1'b1;
                            bus.cpu_reset <= 1'b0;
`endif
                        end else if (word_s > 32'(DEPTH)) begin
                            state_r      <= S_ERR;
                            bus.load_err <= 1'b1;
                        end else begin
                            state_r <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_waddr <= count_r[ADDR_W-1:0];
                        bus.imem_wdata <= word_s;
                        count_r        <= count_r + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r         <= word_sum(csum_r, word_s);
`endif
                        if ((count_r + 32'd1) == n_r) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_r <= S_CSUM;
`else
                            state_r       <= S_DONE;
                            bus.load_done <= 1'b1;
                            bus.cpu_reset <= 1'b0;
`endif
                        end else begin
                            state_r <= S_DATA;
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (word_s == csum_r) begin
                            state_r       <= S_DONE;
                            bus.load_done <= 1'b1;
                            bus.cpu_reset <= 1'b0;
                        end else begin
                            state_r      <= S_ERR;
                            bus.load_err <= 1'b1;
                        end
                    end
`endif
                    default: state_r <= state_r;
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected memory writes
// into a queue, a negedge monitor pops and compares every imem_we pulse.
module tb_imem_loader;
    logic clk;
    logic reset;

    imem_loader_if #(.ADDR_W(14)) bus ();

    imem_loader #(.ADDR_W(14), .DEPTH(16384)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  writes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every write pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_t e;
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0h data=%08h, expected no write",
                         bus.imem_waddr, bus.imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.imem_waddr !== e.addr || bus.imem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write got addr=%0h data=%08h, expected addr=%0h data=%08h",
                             bus.imem_waddr, bus.imem_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [13:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        if (gap > 0) idle(gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send(t[7:0], gap);
            t = t >> 8;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
        writes = 0;
    endtask

    task automatic end_test(input string name, input int exp_writes);
        idle(3);
        check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_write_count"}, 32'(writes), 32'(exp_writes));
        exp_q.delete();
    endtask

    initial begin
        reset        = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        idle(2);
        check("rst_we",        32'(bus.imem_we),    32'd0);
        check("rst_waddr",     32'(bus.imem_waddr), 32'd0);
        check("rst_wdata",     bus.imem_wdata,      32'd0);
        check("rst_cpu_reset", 32'(bus.cpu_reset),  32'd1);
        check("rst_done",      32'(bus.load_done),  32'd0);
        check("rst_err",       32'(bus.load_err),   32'd0);
        reset = 1'b0;
        idle(1);
        writes = 0;

        // Test 1: N=2, words 0x13 and 0x6F with idle gaps.
        expect_wr(14'd0, 32'h0000_0013);
        expect_wr(14'd1, 32'h0000_006F);
        send_word(32'd2, 1);
        send_word(32'h0000_0013, 1);
        send_word(32'h0000_006F, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t1_done_before_csum", 32'(bus.load_done), 32'd0);
        send_word(32'h0000_0082, 1);
`endif
        check("t1_done",      32'(bus.load_done), 32'd1);
        check("t1_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        check("t1_err",       32'(bus.load_err),  32'd0);
        end_test("t1", 2);

        // Test 2: N=0, no writes.
        do_reset();
        send_word(32'd0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t2_done_before_csum", 32'(bus.load_done), 32'd0);
        send_word(32'd0, 0);
`endif
        check("t2_done",      32'(bus.load_done), 32'd1);
        check("t2_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        end_test("t2", 0);

        // Test 3: N=DEPTH+1 overflows; following bytes ignored.
        do_reset();
        send_word(32'd16385, 0);
        check("t3_err",       32'(bus.load_err),  32'd1);
        check("t3_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        send_word(32'h1234_5678, 0);
        send_word(32'h9ABC_DEF0, 0);
        check("t3_done_after", 32'(bus.load_done), 32'd0);
        check("t3_err_after",  32'(bus.load_err),  32'd1);
        check("t3_cpu_after",  32'(bus.cpu_reset), 32'd1);
        end_test("t3", 0);

        // Test 4: back-to-back bytes, N=3.
        do_reset();
        expect_wr(14'd0, 32'h1122_3344);
        expect_wr(14'd1, 32'hA5A5_A5A5);
        expect_wr(14'd2, 32'h0000_0001);
        send_word(32'd3, 0);
        send_word(32'h1122_3344, 0);
        send_word(32'hA5A5_A5A5, 0);
        send_word(32'h0000_0001, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'hB6C7_D8EA, 0);
`endif
        check("t4_done",      32'(bus.load_done), 32'd1);
        check("t4_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        end_test("t4", 3);

        // Test 5: reset mid-load after 6 data bytes, then fresh N=1 stream.
        do_reset();
        expect_wr(14'd0, 32'h0403_0201);
        send_word(32'd2, 0);
        for (int i = 1; i <= 6; i++) send(8'(i), 0);
        idle(2);
        reset = 1'b1;
        #2;
        check("t5_mid_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check("t5_mid_we",        32'(bus.imem_we),   32'd0);
        idle(1);
        reset = 1'b0;
        idle(1);
        expect_wr(14'd0, 32'hDEAD_BEEF);
        send_word(32'd1, 0);
        send_word(32'hDEAD_BEEF, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'hDEAD_BEEF, 0);
`endif
        check("t5_done",      32'(bus.load_done), 32'd1);
        check("t5_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        end_test("t5", 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Test 6a: checksum match.
        do_reset();
        expect_wr(14'd0, 32'd1);
        expect_wr(14'd1, 32'd2);
        send_word(32'd2, 0);
        send_word(32'd1, 0);
        send_word(32'd2, 0);
        send_word(32'd3, 0);
        check("t6a_done", 32'(bus.load_done), 32'd1);
        check("t6a_err",  32'(bus.load_err),  32'd0);
        end_test("t6a", 2);

        // Test 6b: checksum mismatch.
        do_reset();
        expect_wr(14'd0, 32'd1);
        expect_wr(14'd1, 32'd2);
        send_word(32'd2, 0);
        send_word(32'd1, 0);
        send_word(32'd2, 0);
        send_word(32'd4, 0);
        check("t6b_done",      32'(bus.load_done), 32'd0);
        check("t6b_err",       32'(bus.load_err),  32'd1);
        check("t6b_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        end_test("t6b", 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
